// File: rtl/dis_frame_scan_out_if.sv
// ---------------------------------------------------------------------------
// dis_frame_scan_out_if
// Pixel stream bundle between the frame scan-out block and the display or
// capture sink. The byte moves when pix_valid and pix_ready are both high.
//   pix_valid  master->slave  byte valid
//   pix_ready  slave->master  sink accepts the byte
//   pix_data   master->slave  8-bit pixel value
//   pix_plane  master->slave  0=Y, 1=Cb, 2=Cr
//   pix_sof    master->slave  first byte of frame
//   pix_eof    master->slave  last byte of frame
//   pix_sol    master->slave  first byte of a line
//   pix_eol    master->slave  last byte of a line
// ---------------------------------------------------------------------------
interface dis_frame_scan_out_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic [1:0] pix_plane;
  logic       pix_sof;
  logic       pix_eof;
  logic       pix_sol;
  logic       pix_eol;

  modport master (
    output pix_valid, pix_data, pix_plane, pix_sof, pix_eof, pix_sol, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_plane, pix_sof, pix_eof, pix_sol, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/dis_frame_scan_out.sv
// ---------------------------------------------------------------------------
// dis_frame_scan_out
// Reads a finished picture out of the display frame RAM (32-bit words, four
// pixels each, leftmost pixel in bits [7:0]) and serialises it into an 8-bit
// raster pixel stream with line/frame/plane framing flags.
//
// Ports:
//   clk                    system clock
//   reset_n                asynchronous active-low reset
//   frame_start            one-cycle pulse, frame in RAM is complete
//   dis_frame_RAM_rd       frame RAM read enable
//   dis_frame_RAM_rd_addr  frame RAM word address (14 bit)
//   dis_frame_RAM_dout     read data, valid one cycle after the read
//   pix                    pixel stream (dis_frame_scan_out_if.master)
//   scan_busy              high while a scan is in progress
//   scan_done              one-cycle pulse after the last byte is accepted
//
// Build option:
//   DIS_SCAN_LUMA_ONLY_EN  when defined only the Y plane is scanned and the
//                          chroma words are never read.
// ---------------------------------------------------------------------------
module dis_frame_scan_out #(
  parameter int PIC_W_MB   = 11,
  parameter int PIC_H_MB   = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_start,
  output logic                        dis_frame_RAM_rd,
  output logic [13:0]                 dis_frame_RAM_rd_addr,
  input  logic [31:0]                 dis_frame_RAM_dout,
  dis_frame_scan_out_if.master        pix,
  output logic                        scan_busy,
  output logic                        scan_done
);

  localparam int WH = PIC_W_MB * PIC_H_MB;
`ifdef DIS_SCAN_LUMA_ONLY_EN
  localparam int         TOT        = 64 * WH;
  localparam logic [1:0] LAST_PLANE = 2'd0;
`else
  localparam int         TOT        = 96 * WH;
  localparam logic [1:0] LAST_PLANE = 2'd2;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] Y_LW = 8'(16 * PIC_W_MB);
  localparam logic [7:0] Y_LH = 8'(16 * PIC_H_MB);
  localparam logic [7:0] C_LW = 8'(8 * PIC_W_MB);
  localparam logic [7:0] C_LH = 8'(8 * PIC_H_MB);

  // The full three-plane frame must fit the 14-bit word address space.
  generate
    if (WH > 170 || PIC_W_MB < 1 || PIC_W_MB > 15 || PIC_H_MB < 1 || PIC_H_MB > 15) begin : g_bad_size
      $error("dis_frame_scan_out: picture size out of range (W*H must be <= 170)");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
      $error("dis_frame_scan_out: FIFO_DEPTH must be a power of two in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [13:0]   rd_cnt;
  logic          inflight;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   ser_word;
  logic [1:0]    ser_idx;
  logic          ser_valid;
  logic [7:0]    x_cnt, y_cnt;
  logic [1:0]    plane;

  logic          start, accept, rd_en, ser_free, ser_load, fifo_pop, fifo_push;
  logic          x_last, y_last, last_byte;
  logic [7:0]    line_w, line_h;
  logic [31:0]   load_word;

  always_comb begin
    start     = (state == IDLE) && frame_start;
    accept    = ser_valid && pix.pix_ready;
    line_w    = (plane == 2'd0) ? Y_LW : C_LW;
    line_h    = (plane == 2'd0) ? Y_LH : C_LH;
    x_last    = (x_cnt == line_w - 8'd1);
    y_last    = (y_cnt == line_h - 8'd1);
    last_byte = accept && x_last && y_last && (plane == LAST_PLANE);
    // Counting the in-flight read keeps the landing word from overflowing the FIFO.
    rd_en     = (state == RUN) && (int'(rd_cnt) < TOT) &&
                ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    // Reloading on the accept of byte 3 gives back-to-back words with no bubble.
    ser_free  = !ser_valid || (accept && ser_idx == 2'd3);
    ser_load  = ser_free && ((fifo_count != '0) || inflight);
    fifo_pop  = ser_load && (fifo_count != '0);
    // With an empty FIFO the arriving RAM word goes straight to the serialiser.
    fifo_push = inflight && !(ser_load && fifo_count == '0);
    load_word = (fifo_count != '0) ? fifo_mem[rd_ptr] : dis_frame_RAM_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // frame_start only matters in IDLE; a pulse during RUN or DONE is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (last_byte)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start)      rd_cnt <= '0;
      else if (rd_en) rd_cnt <= rd_cnt + 14'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= dis_frame_RAM_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_word  <= '0;
      ser_idx   <= '0;
      ser_valid <= 1'b0;
    end else if (ser_load) begin
      ser_word  <= load_word;
      ser_idx   <= '0;
      ser_valid <= 1'b1;
    end else if (accept) begin
      if (ser_idx == 2'd3) ser_valid <= 1'b0;
      else                 ser_idx   <= ser_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      plane <= '0;
    end else if (start) begin
      x_cnt <= '0;
      y_cnt <= '0;
      plane <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_cnt <= '0;
        if (y_last) begin
          y_cnt <= '0;
          plane <= (plane == LAST_PLANE) ? 2'd0 : plane + 2'd1;
        end else begin
          y_cnt <= y_cnt + 8'd1;
        end
      end else begin
        x_cnt <= x_cnt + 8'd1;
      end
    end
  end

  // Flags come straight from the counters, which only move on an accepted
  // byte, so everything on the stream holds still while stalled.
  always_comb begin
    pix.pix_valid         = ser_valid;
    pix.pix_data          = ser_word[{ser_idx, 3'b000} +: 8];
    pix.pix_plane         = plane;
    pix.pix_sof           = ser_valid && (plane == 2'd0) && (x_cnt == 8'd0) && (y_cnt == 8'd0);
    pix.pix_eof           = ser_valid && (plane == LAST_PLANE) && x_last && y_last;
    pix.pix_sol           = ser_valid && (x_cnt == 8'd0);
    pix.pix_eol           = ser_valid && x_last;
    dis_frame_RAM_rd      = rd_en;
    dis_frame_RAM_rd_addr = rd_cnt;
    scan_busy             = (state != IDLE);
    scan_done             = (state == DONE);
  end

endmodule

// File: doc/dis_frame_scan_out.md
Name: dis_frame_scan_out

Overview:
- Downstream consumer of the deblocking filter's display frame RAM.
- Once the last MB of a picture has been filtered, it reads the finished frame out of the frame RAM word by word (32 bit = 4 pixels).
- It serialises the words into an 8-bit raster pixel stream with a valid/ready handshake and line/frame/plane framing flags, for the display or host capture port.

Parameters:
- PIC_W_MB, 11, picture width in macroblocks (1..15).
- PIC_H_MB, 9, picture height in macroblocks (1..15).
- FIFO_DEPTH, 4, word prefetch FIFO depth; power of two, 2..8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse: frame in RAM is complete (driven from end of last MB DF).
- dis_frame_RAM_rd  out  1  frame RAM read enable.
- dis_frame_RAM_rd_addr  out  14  frame RAM word read address.
- dis_frame_RAM_dout  in  32  read data, valid exactly 1 cycle after rd.
- pix_valid  out  1  pixel byte valid.
- pix_ready  in  1  sink accepts byte when pix_valid&pix_ready.
- pix_data  out  8  pixel value.
- pix_plane  out  2  0=Y, 1=Cb, 2=Cr.
- pix_sof  out  1  first byte of frame.
- pix_eof  out  1  last byte of frame.
- pix_sol  out  1  first byte of a line.
- pix_eol  out  1  last byte of a line.
- scan_busy  out  1  high while a frame scan is in progress; the decoder does not write the frame RAM while high.
- scan_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Memory layout, with W=PIC_W_MB and H=PIC_H_MB:
  - Y plane: words 0..64WH-1, raster, 4W words per line, 16H lines.
  - Cb plane: base 64WH, 16WH words, 2W words per line, 8H lines.
  - Cr plane: base 80WH, same shape as Cb.
  - Total TOT=96WH words; the max config (15x15) is 21600 words, which exceeds 14 bits. W*H is therefore limited to 170, and an elaboration check is required.
  - Scan order is linear address 0..TOT-1.
- Byte order within a word: bits[7:0] is the leftmost pixel, then [15:8], [23:16], [31:24].
- FSM states:
  - IDLE: frame_start → RUN, clear counters, scan_busy=1 from the next cycle.
  - RUN: the read counter issues reads; once the last byte is accepted → DONE.
  - DONE: one cycle; scan_done=1, scan_busy=0 next cycle → IDLE.
- frame_start is ignored outside IDLE.
- Read issue rule: assert rd when rd_cnt<TOT and (fifo_count + inflight) < FIFO_DEPTH. inflight is 1 in the cycle after a read and 0 otherwise. Data is captured into the FIFO one cycle after rd; the FIFO never overflows.
- Serialiser:
  - Holds one word plus a 2-bit byte index.
  - Loads from the FIFO when empty, or when its last byte is accepted in the same cycle. This gives zero-bubble streaming at 1 byte/cycle when pix_ready stays high.
  - pix_data and all flags are stable while pix_valid & !pix_ready.
- Framing counters advance on each accepted byte:
  - x runs 0..LW-1, where LW=16W for Y and 8W for chroma.
  - y runs 0..LH-1.
  - plane runs 0..2.
  - pix_sol = (x==0); pix_eol = (x==LW-1).
  - pix_sof = (plane==0,x==0,y==0); pix_eof = (plane==2, last x, last y).
- Latency: first pix_valid appears 3 cycles after frame_start (state→rd→data→serialiser).
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters 0.
- Reset asserted mid-scan aborts immediately; no scan_done is generated.
- frame_start coincident with scan_done (DONE state) is ignored.

Optional Feature:
- Macro: DIS_SCAN_LUMA_ONLY_EN.
- Defined: only the Y plane is scanned, TOT=64WH. pix_eof is on the last Y byte and pix_plane is always 0. Chroma words are never read.
- Undefined: full Y/Cb/Cr scan as above.

Test Plan:
- W=1, H=1, RAM word i = {4{i[7:0]}}, pix_ready=1, pulse frame_start:
  - exactly 384 bytes are produced, contiguous from cycle 3.
  - byte n equals (n>>2).
  - pix_plane changes at bytes 256 and 320.
  - scan_done is asserted 1 cycle after byte 383.
- Same setup with pix_ready toggling 1-of-3 cycles: byte sequence is identical; FIFO never exceeds 4; data is held stable while stalled.
- Framing flags, W=2, H=1: pix_sol at Y bytes 0,32,64…; pix_eol at 31,63…; chroma lines are 16 bytes; pix_sof on byte 0 only; pix_eof on byte 767 only.
- frame_start re-pulsed mid-scan (at byte 100): ignored, and the total is still 384 bytes.
- reset_n asserted at byte 200, then a new frame_start: scan restarts from address 0 with pix_sof set, and no scan_done is produced for the aborted scan.
- With DIS_SCAN_LUMA_ONLY_EN defined, W=1, H=1: 256 bytes, max rd address 63, pix_eof on byte 255.
